// File: rtl/lc3_bus_pkg.sv
// Shared definitions for the LC-3 memory/I-O bus initiator and its helpers.
// Latency: n/a (constants, types and helper functions only).
// Backpressure: n/a.
package lc3_bus_pkg;

  // Default bus/data width and default wait-for-R budget in cycles.
  localparam int DW              = 16;
  localparam int TIMEOUT_CYC_DEF = 1023;

  typedef logic [2:0] state_t;

  // Master sequencer states. These are plain constants so the encoding stays
  // stable for any legacy tooling that decodes the state register directly.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_WDATA = 3'd2;
  localparam logic [2:0] S_WWAIT = 3'd3;
  localparam logic [2:0] S_RWAIT = 3'd4;
  localparam logic [2:0] S_GATE  = 3'd5;
  localparam logic [2:0] S_FIN   = 3'd6;
  localparam logic [2:0] S_ABORT = 3'd7;

  // True in the two states that wait for R from the memory subsystem.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_WWAIT) || (s == S_RWAIT);
  endfunction

endpackage

// File: rtl/lc3_mem_master_if.sv
// LC-3 memory/I-O subsystem bus: BUS drive/sample plus MAR/MDR/MIO_EN/R_W/R handshake.
// Latency: n/a (wires only).
// Backpressure: the subsystem stalls the initiator by holding R low.
//
// Signals:
//   bus_in   current value of the shared tristate BUS
//   bus_out  value the initiator wants on BUS, valid while bus_oe=1
//   bus_oe   initiator drive enable for bus_out
//   LD_MAR   load MAR from BUS
//   LD_MDR   load MDR (from BUS when MIO_EN=0, from device when MIO_EN=1)
//   MIO_EN   memory/I-O access enable
//   R_W      1=write, 0=read
//   GateMDR  subsystem drives MDR onto BUS
//   R        ready from the subsystem
interface lc3_mem_master_if #(
  parameter int DW = lc3_bus_pkg::DW
);
  logic [DW-1:0] bus_in;
  logic [DW-1:0] bus_out;
  logic          bus_oe;
  logic          LD_MAR;
  logic          LD_MDR;
  logic          MIO_EN;
  logic          R_W;
  logic          GateMDR;
  logic          R;

  // CPU-side initiator view.
  modport master (
    input  bus_in,
    input  R,
    output bus_out,
    output bus_oe,
    output LD_MAR,
    output LD_MDR,
    output MIO_EN,
    output R_W,
    output GateMDR
  );

  // Memory subsystem view.
  modport slave (
    output bus_in,
    output R,
    input  bus_out,
    input  bus_oe,
    input  LD_MAR,
    input  LD_MDR,
    input  MIO_EN,
    input  R_W,
    input  GateMDR
  );
endinterface

// File: rtl/lc3_wait_timer.sv
// Bounded wait counter: clears on load, counts enabled cycles, flags the last allowed cycle.
// Latency: expire is combinational from the count, valid in the LIMIT-th enabled cycle.
// Backpressure: none; the caller decides what to do on expire.
//
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   load        clear the count (takes priority over en)
//   en          count this cycle as one waited cycle
//   expire      high during the LIMIT-th consecutive enabled cycle after a load
module lc3_wait_timer #(
  parameter int LIMIT = lc3_bus_pkg::TIMEOUT_CYC_DEF,
  parameter int CW    = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          at_last;

  // cnt_q holds the number of enabled cycles already completed, so the
  // LIMIT-th enabled cycle sees LIMIT-1 here.
  assign at_last = (cnt_q == CW'(LIMIT - 1));
  assign expire  = en && !load && at_last;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en && !at_last) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lc3_mem_master.sv
// CPU-side initiator for the LC-3 memory/I-O bus: single-word read/write with timeout.
// Latency: req to done is 3+k cycles for both reads and writes (k = cycles spent waiting for R).
// Backpressure: busy high while a transaction is open; req is ignored (not queued) unless idle.
//
// Ports:
//   clk, rst_n           clock and synchronous active-low reset
//   req/we/addr/wdata    request from the control unit, sampled only when idle
//   busy                 high whenever a transaction is in progress
//   done / err           one-cycle completion / timeout-abort pulses
//   rdata                last successful read result, held until the next one
//   mbus                 memory subsystem bus (BUS drive/sample and handshake strobes)
module lc3_mem_master
  import lc3_bus_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int DW          = lc3_bus_pkg::DW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [DW-1:0]         addr,
  input  logic [DW-1:0]         wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DW-1:0]         rdata,
  lc3_mem_master_if.master      mbus
);

  typedef struct packed {
    logic          we;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  state_t        state_q;
  state_t        state_d;
  txn_t          txn_q;
  txn_t          txn_d;
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] rdata_d;

  logic          in_wait;
  logic          tmr_expire;

  assign in_wait = is_wait_state(state_q);

  // The count is held clear in every non-wait state, so each entry into
  // WWAIT/RWAIT starts a fresh budget of TIMEOUT_CYC cycles.
  lc3_wait_timer #(
    .LIMIT (TIMEOUT_CYC)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (!in_wait),
    .en     (in_wait),
    .expire (tmr_expire)
  );

  // Next-state and datapath capture.
  always_comb begin
    state_d = state_q;
    txn_d   = txn_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          txn_d.we    = we;
          txn_d.addr  = addr;
          txn_d.wdata = wdata;
          state_d     = S_ADDR;
        end
      end
      S_ADDR:  state_d = txn_q.we ? S_WDATA : S_RWAIT;
      S_WDATA: state_d = S_WWAIT;
      // R is checked before the timer, so a ready arriving in the last
      // allowed cycle still completes the transaction.
      S_WWAIT: begin
        if (mbus.R) begin
          state_d = S_FIN;
        end else if (tmr_expire) begin
          state_d = S_ABORT;
        end
      end
      S_RWAIT: begin
        if (mbus.R) begin
          state_d = S_GATE;
        end else if (tmr_expire) begin
          state_d = S_ABORT;
        end
      end
      S_GATE: begin
        rdata_d = mbus.bus_in;
        state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      txn_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      txn_q   <= txn_d;
      rdata_q <= rdata_d;
    end
  end

  // Moore output decode from the state register and the latched request.
  always_comb begin
    busy         = (state_q != S_IDLE);
    done         = 1'b0;
    err          = 1'b0;
    mbus.bus_out = '0;
    mbus.bus_oe  = 1'b0;
    mbus.LD_MAR  = 1'b0;
    mbus.LD_MDR  = 1'b0;
    mbus.MIO_EN  = 1'b0;
    mbus.R_W     = 1'b0;
    mbus.GateMDR = 1'b0;
    case (state_q)
      S_ADDR: begin
        mbus.bus_out = txn_q.addr;
        mbus.bus_oe  = 1'b1;
        mbus.LD_MAR  = 1'b1;
      end
      S_WDATA: begin
        mbus.bus_out = txn_q.wdata;
        mbus.bus_oe  = 1'b1;
        mbus.LD_MDR  = 1'b1;
        // R_W is raised one cycle ahead of MIO_EN (harmless while MIO_EN=0)
        // so it never toggles while an access is enabled.
        mbus.R_W     = 1'b1;
      end
      S_WWAIT: begin
        mbus.MIO_EN  = 1'b1;
        mbus.R_W     = 1'b1;
      end
      S_RWAIT: begin
        mbus.MIO_EN  = 1'b1;
        mbus.LD_MDR  = 1'b1;
      end
      S_GATE: begin
        mbus.GateMDR = 1'b1;
      end
      // R_W is held through the closing cycle for writes so it only falls
      // once MIO_EN has already been low for a cycle.
      S_FIN: begin
        done         = 1'b1;
        mbus.R_W     = txn_q.we;
      end
      S_ABORT: begin
        err          = 1'b1;
        mbus.R_W     = txn_q.we;
      end
      default: begin
        busy         = 1'b0;
      end
    endcase
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_lc3_mem_master.sv
module tb_lc3_mem_master;

  localparam int TO    = 8;
  localparam int NEVER = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] rdata;

  lc3_mem_master_if #(.DW(16)) mbus ();

  lc3_mem_master #(.TIMEOUT_CYC(TO), .DW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .rdata (rdata),
    .mbus  (mbus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Memory subsystem: device memory plus KBSR at 0xFE00 reading as 0x8000.
  logic [15:0] dev_mem [16];
  logic [15:0] mar      = 16'h0;
  logic [15:0] mdr      = 16'h0;
  int          mio_cnt  = 0;
  int          k_cur    = NEVER;
  logic        prev_rw  = 1'b0;
  logic        prev_mio = 1'b0;
  logic        prev_rst = 1'b0;

  always @(negedge clk) begin
    if (mbus.LD_MAR) mar = mbus.bus_out;
    if (mbus.LD_MDR && !mbus.MIO_EN) mdr = mbus.bus_out;
    if (mbus.MIO_EN) begin
      mio_cnt++;
      if (mio_cnt == k_cur) begin
        mbus.R = 1'b1;
        if (mbus.R_W) dev_mem[mar[3:0]] = mdr;
        else mdr = (mar == 16'hFE00) ? 16'h8000 : dev_mem[mar[3:0]];
      end
    end else begin
      mio_cnt = 0;
      mbus.R  = 1'b0;
    end
    mbus.bus_in = mbus.GateMDR ? mdr : (mbus.bus_oe ? mbus.bus_out : 16'($urandom));
    if (rst_n && prev_rst) begin
      check_eq("oe_vs_gate", 32'(mbus.bus_oe & mbus.GateMDR), 32'd0);
      check_eq("mar_vs_mio", 32'(mbus.LD_MAR & mbus.MIO_EN), 32'd0);
      if (mbus.R_W !== prev_rw) check_eq("rw_change_mio", 32'({prev_mio, mbus.MIO_EN}), 32'd0);
    end
    prev_rw  = mbus.R_W;
    prev_mio = mbus.MIO_EN;
    prev_rst = rst_n;
  end

  // Transaction-level reference.
  logic [15:0] ref_mem [16];
  logic [15:0] exp_rdata;

  function automatic logic [15:0] ref_read(input logic [15:0] a);
    return (a == 16'hFE00) ? 16'h8000 : ref_mem[a[3:0]];
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_ctl"}, 32'({busy, done, err, mbus.bus_oe, mbus.LD_MAR, mbus.LD_MDR,
                               mbus.MIO_EN, mbus.R_W, mbus.GateMDR}), 32'd0);
    check_eq({tag, "_rdata"}, 32'(rdata), 32'(exp_rdata));
    check_eq({tag, "_bus_out"}, 32'(mbus.bus_out), 32'd0);
  endtask

  task automatic idle_chk();
    step();
    check_eq("no_extra_txn", 32'(busy), 32'd0);
  endtask

  // One transaction. Called at a negedge. k = wait cycle in which R appears.
  // off=1 means the DUT is finishing a previous transaction (req held through FIN).
  task automatic run_txn(input logic w, input logic [15:0] a, input logic [15:0] d,
                         input int k, input bit hold, input int off, input bit noise);
    bit          ok       = (k <= TO);
    int          exp_end  = off + 3 + (ok ? k : (w ? TO : TO - 1));
    int          end_cyc  = 0;
    int          mar_cyc  = 0;
    int          mdr_cyc  = 0;
    int          mio_cyc  = 0;
    int          gate_cyc = 0;
    int          busy_gap = 0;
    bit          fin      = 0;
    bit          got_done = 0;
    bit          got_err  = 0;
    bit          idle_seen = 0;
    bit          mio_end  = 1;
    logic [15:0] mar_val  = 16'h0;
    logic [15:0] mdr_val  = 16'h0;
    logic [15:0] got_rd   = 16'h0;
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    k_cur = k;
    for (int c = 1; c <= exp_end + 4 && !fin; c++) begin
      step();
      if (c > off) begin
        if (hold) req = 1'b1;
        else if (noise && $urandom_range(0, 3) == 0) begin
          req   = 1'b1;
          we    = 1'($urandom);
          addr  = 16'($urandom);
          wdata = 16'($urandom);
        end else req = 1'b0;
      end
      if (c <= off) begin
        if (!busy) idle_seen = 1;
      end else if (!busy) busy_gap++;
      if (mbus.LD_MAR && mar_cyc == 0) begin mar_cyc = c; mar_val = mbus.bus_out; end
      if (mbus.LD_MDR && !mbus.MIO_EN && mdr_cyc == 0) begin mdr_cyc = c; mdr_val = mbus.bus_out; end
      if (mbus.MIO_EN) mio_cyc++;
      if (mbus.GateMDR) gate_cyc++;
      if (done || err) begin
        fin      = 1;
        end_cyc  = c;
        got_done = done;
        got_err  = err;
        got_rd   = rdata;
        mio_end  = mbus.MIO_EN;
        if (!hold) req = 1'b0;
      end
    end
    if (ok && w) ref_mem[a[3:0]] = d;
    if (ok && !w) exp_rdata = ref_read(a);
    check_eq("end_cycle", 32'(end_cyc), 32'(exp_end));
    check_eq("done_pulse", 32'(got_done), 32'(ok));
    check_eq("err_pulse", 32'(got_err), 32'(!ok));
    check_eq("ld_mar_cycle", 32'(mar_cyc), 32'(off + 1));
    check_eq("ld_mar_addr", 32'(mar_val), 32'(a));
    if (w) begin
      check_eq("ld_mdr_cycle", 32'(mdr_cyc), 32'(off + 2));
      check_eq("ld_mdr_wdata", 32'(mdr_val), 32'(d));
    end
    check_eq("mio_cycles", 32'(mio_cyc), 32'(ok ? k : TO));
    check_eq("gate_cycles", 32'(gate_cyc), 32'((ok && !w) ? 1 : 0));
    check_eq("busy_gap", 32'(busy_gap), 32'd0);
    if (off > 0) check_eq("b2b_idle", 32'(idle_seen), 32'd1);
    check_eq("mio_at_end", 32'(mio_end), 32'd0);
    check_eq("rdata", 32'(got_rd), 32'(exp_rdata));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        w;
    logic [15:0] a;
    rst_n     = 1'b0;
    req       = 1'b0;
    we        = 1'b0;
    addr      = 16'h0;
    wdata     = 16'h0;
    exp_rdata = 16'h0;
    for (int i = 0; i < 16; i++) begin
      dev_mem[i] = 16'($urandom);
      ref_mem[i] = dev_mem[i];
    end
    dev_mem[0] = 16'h1234;
    ref_mem[0] = 16'h1234;

    repeat (2) step();
    check_quiet("reset");
    rst_n = 1'b1;
    step();
    check_quiet("idle");

    // Directed cases.
    run_txn(1'b0, 16'h3000, 16'h0000, 3, 0, 0, 0);  idle_chk();
    run_txn(1'b1, 16'h3000, 16'hBEEF, 2, 0, 0, 0);  idle_chk();
    run_txn(1'b0, 16'h3000, 16'h0000, 1, 0, 0, 0);  idle_chk();
    run_txn(1'b0, 16'hFE00, 16'h0000, 1, 0, 0, 0);  idle_chk();
    run_txn(1'b1, 16'h3002, 16'hDEAD, NEVER, 0, 0, 0); idle_chk();
    run_txn(1'b0, 16'h3002, 16'h0000, NEVER, 0, 0, 0); idle_chk();
    run_txn(1'b0, 16'h3002, 16'h0000, TO, 0, 0, 0);    idle_chk();
    run_txn(1'b1, 16'h3004, 16'h4444, TO, 0, 0, 0);    idle_chk();

    // Reset while waiting for R on a read.
    req   = 1'b1;
    we    = 1'b0;
    addr  = 16'h3003;
    k_cur = NEVER;
    step();
    req = 1'b0;
    step();
    step();
    check_eq("pre_reset_mio", 32'(mbus.MIO_EN), 32'd1);
    rst_n     = 1'b0;
    exp_rdata = 16'h0;
    step();
    check_quiet("mid_reset");
    rst_n = 1'b1;
    step();
    check_eq("post_reset_busy", 32'(busy), 32'd0);
    run_txn(1'b1, 16'h3003, 16'h5A5A, 2, 0, 0, 0); idle_chk();
    run_txn(1'b0, 16'h3003, 16'h0000, 2, 0, 0, 0); idle_chk();

    // req held high across two back-to-back transactions.
    run_txn(1'b1, 16'h3005, 16'hA5A5, 1, 1, 0, 0);
    run_txn(1'b0, 16'h3005, 16'h0000, 2, 0, 1, 0); idle_chk();

    // Randomized traffic with stray req pulses while busy.
    for (int n = 0; n < 40; n++) begin
      w = 1'($urandom);
      if (!w && $urandom_range(0, 4) == 0) a = 16'hFE00;
      else a = 16'h3000 | 16'($urandom_range(0, 15));
      run_txn(w, a, 16'($urandom), $urandom_range(1, TO + 2), 0, 0, 1);
      idle_chk();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
